// File: rtl/mac_sequencer.sv
// Dot-product sequencer: streams (a,b) pairs into an external fused multiply-add
// and keeps the running fp32 accumulator, returning the sum over a valid/ready port.
module mac_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic [15:0]      fma_a,
    output logic [15:0]      fma_b,
    output logic [31:0]      fma_c,
    input  logic [31:0]      fma_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             busy,
    output logic [LEN_W-1:0] done_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    state_t           state, state_nx;
    logic [31:0]      acc, acc_nx;
    logic [LEN_W-1:0] rem, rem_nx;
    logic [LEN_W-1:0] cnt, cnt_nx;
    logic             accept;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; ready never looks at valid, and valid/data stay put until the transfer.
    assign in_ready  = (state == ACCUM);
    assign accept    = in_valid && in_ready;
    assign res_valid = (state == DONE);
    assign res_data  = acc;
    assign busy      = (state != IDLE);
    assign done_cnt  = cnt;

    // The multiply-add is external; this block only routes operands and the addend.
    assign fma_a = in_a;
    assign fma_b = in_b;
    assign fma_c = acc;

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        rem_nx   = rem;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_nx = bias;
                    cnt_nx = '0;
                    if (len != '0) begin
                        rem_nx   = len;
                        state_nx = ACCUM;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nx = fma_out;
                    rem_nx = rem - ONE;
                    cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + ONE;
                    if (rem == ONE) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            rem   <= rem_nx;
            cnt   <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: the FMA is stubbed by a scripted value or a
// bench-side mixing function, and a per-vector model predicts the accumulator chain.
module tb_mac_sequencer;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [31:0]      bias;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic [15:0]      fma_a;
    logic [15:0]      fma_b;
    logic [31:0]      fma_c;
    logic [31:0]      fma_out;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic             busy;
    logic [LEN_W-1:0] done_cnt;

    logic             script_mode;
    logic [31:0]      script_val;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [31:0]      exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mac_sequencer #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .fma_a     (fma_a),
        .fma_b     (fma_b),
        .fma_c     (fma_c),
        .fma_out   (fma_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    // Stand-in for the fused multiply-add: any deterministic mix of all three operands
    // is enough to prove the accumulator chain and operand routing.
    function automatic logic [31:0] stub_fn(input logic [15:0] a, input logic [15:0] b,
                                            input logic [31:0] c);
        return ({a, b} ^ {c[30:0], c[31]}) + 32'h9E37_79B9;
    endfunction

    assign fma_out = script_mode ? script_val : stub_fn(fma_a, fma_b, fma_c);

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        len       = '0;
        bias      = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        start = 1'b1;
        len   = 8'd5;
        bias  = 32'h1234_5678;
        tick();
        tick();
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %0b want 0", res_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (res_data !== 32'h0) begin n_err++; $display("FAIL reset_res_data: got %h want 0", res_data); end
        n_cmp++; if (done_cnt !== '0) begin n_err++; $display("FAIL reset_done_cnt: got %0d want 0", done_cnt); end
        n_cmp++; if (fma_c !== 32'h0) begin n_err++; $display("FAIL reset_fma_c: got %h want 0", fma_c); end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL after_reset_busy: got %0b want 0", busy); end
        tick();
    endtask

    task automatic test_scripted();
        logic [31:0] vals[3];
        logic [31:0] exp_c;
        vals  = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        script_mode = 1'b1;
        start = 1'b1;
        len   = 8'd3;
        bias  = 32'h3F80_0000;
        tick();
        start = 1'b0;
        exp_c = 32'h3F80_0000;
        for (int k = 0; k < 3; k++) begin
            in_valid   = 1'b1;
            in_a       = 16'($urandom);
            in_b       = 16'($urandom);
            script_val = vals[k];
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL scr_in_ready[%0d]: got %0b want 1", k, in_ready); end
            n_cmp++; if (fma_c !== exp_c) begin n_err++; $display("FAIL scr_fma_c[%0d]: got %h want %h", k, fma_c, exp_c); end
            n_cmp++; if (done_cnt !== LEN_W'(k)) begin n_err++; $display("FAIL scr_done_cnt[%0d]: got %0d want %0d", k, done_cnt, k); end
            n_cmp++; if (fma_a !== in_a || fma_b !== in_b) begin n_err++; $display("FAIL scr_operands[%0d]: got %h/%h want %h/%h", k, fma_a, fma_b, in_a, in_b); end
            tick();
            exp_c = vals[k];
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL scr_res_valid: got %0b want 1", res_valid); end
        n_cmp++; if (res_data !== 32'h4080_0000) begin n_err++; $display("FAIL scr_res_data: got %h want 40800000", res_data); end
        n_cmp++; if (done_cnt !== 8'd3) begin n_err++; $display("FAIL scr_done_cnt_end: got %0d want 3", done_cnt); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL scr_in_ready_done: got %0b want 0", in_ready); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_err++; $display("FAIL scr_back_idle: got busy=%0b res_valid=%0b want 0/0", busy, res_valid); end
        n_cmp++; if (res_data !== 32'h4080_0000) begin n_err++; $display("FAIL scr_idle_res_data: got %h want 40800000", res_data); end
        script_mode = 1'b0;
        tick();
    endtask

    task automatic test_len_zero();
        start = 1'b1;
        len   = '0;
        bias  = 32'hC0A0_0000;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lz_in_ready_idle: got %0b want 0", in_ready); end
        tick();
        start = 1'b0;
        @(negedge clk);
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL lz_res_valid: got %0b want 1", res_valid); end
        n_cmp++; if (res_data !== 32'hC0A0_0000) begin n_err++; $display("FAIL lz_res_data: got %h want c0a00000", res_data); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lz_in_ready_done: got %0b want 0", in_ready); end
        n_cmp++; if (done_cnt !== '0) begin n_err++; $display("FAIL lz_done_cnt: got %0d want 0", done_cnt); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL lz_back_idle: got %0b want 0", busy); end
        tick();
    endtask

    task automatic test_stall();
        logic        pat[6];
        logic [31:0] exp_acc;
        int          exp_cnt;
        pat     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_acc = 32'($urandom);
        exp_cnt = 0;
        start   = 1'b1;
        len     = 8'd4;
        bias    = exp_acc;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = pat[i];
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            @(negedge clk);
            n_cmp++; if (fma_c !== exp_acc) begin n_err++; $display("FAIL stall_acc[%0d]: got %h want %h", i, fma_c, exp_acc); end
            n_cmp++; if (done_cnt !== LEN_W'(exp_cnt)) begin n_err++; $display("FAIL stall_cnt[%0d]: got %0d want %0d", i, done_cnt, exp_cnt); end
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %0b want 1", i, in_ready); end
            if (in_valid) begin
                exp_acc = stub_fn(in_a, in_b, exp_acc);
                exp_cnt++;
            end
            tick();
        end
        in_valid = 1'b1;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        @(negedge clk);
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL stall_res_valid: got %0b want 1", res_valid); end
        n_cmp++; if (done_cnt !== 8'd4) begin n_err++; $display("FAIL stall_done_cnt: got %0d want 4", done_cnt); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready_done: got %0b want 0", in_ready); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (res_data !== exp_acc) begin n_err++; $display("FAIL stall_res_data: got %h want %h", res_data, exp_acc); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_hold_done();
        logic [31:0] exp_res;
        logic [31:0] b0;
        b0    = 32'($urandom);
        start = 1'b1;
        len   = 8'd1;
        bias  = b0;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        exp_res  = stub_fn(in_a, in_b, b0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            res_ready = 1'b0;
            start     = (i == 2);
            len       = 8'd5;
            bias      = 32'($urandom);
            @(negedge clk);
            n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL hold_res_valid[%0d]: got %0b want 1", i, res_valid); end
            n_cmp++; if (res_data !== exp_res) begin n_err++; $display("FAIL hold_res_data[%0d]: got %h want %h", i, res_data, exp_res); end
            n_cmp++; if (done_cnt !== 8'd1) begin n_err++; $display("FAIL hold_done_cnt[%0d]: got %0d want 1", i, done_cnt); end
            tick();
        end
        res_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd3;
        bias      = ~exp_res;
        @(negedge clk);
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL hold_release_valid: got %0b want 1", res_valid); end
        tick();
        start     = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_err++; $display("FAIL hold_idle: got busy=%0b res_valid=%0b want 0/0", busy, res_valid); end
        n_cmp++; if (res_data !== exp_res) begin n_err++; $display("FAIL hold_start_ignored: got %h want %h", res_data, exp_res); end
        tick();
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        len   = 8'd5;
        bias  = 32'($urandom) | 32'h1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            tick();
        end
        rst       = 1'b1;
        start     = 1'b1;
        res_ready = 1'b1;
        tick();
        rst       = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %0b want 0", busy); end
        n_cmp++; if (res_data !== 32'h0) begin n_err++; $display("FAIL rmid_acc: got %h want 0", res_data); end
        n_cmp++; if (done_cnt !== '0) begin n_err++; $display("FAIL rmid_done_cnt: got %0d want 0", done_cnt); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_in_ready: got %0b want 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rmid_res_valid[%0d]: got %0b want 0", i, res_valid); end
            tick();
            @(negedge clk);
        end
        tick();
    endtask

    task automatic test_start_with_rst();
        rst   = 1'b1;
        start = 1'b1;
        len   = 8'd4;
        bias  = 32'($urandom);
        tick();
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_start_busy: got %0b want 0", busy); end
        n_cmp++; if (res_data !== 32'h0) begin n_err++; $display("FAIL rst_start_acc: got %h want 0", res_data); end
        tick();
    endtask

    // Random vectors with gapped input, stray start pulses and delayed result
    // acceptance; the last vector uses the maximum length.
    task automatic test_random();
        logic [31:0] exp_acc;
        int          vlen;
        int          rem;
        int          cnt;
        int          guard;
        logic [31:0] got;
        for (int v = 0; v < 13; v++) begin
            vlen = (v == 12) ? 255 : $urandom_range(1, 12);
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            exp_acc = 32'($urandom);
            start   = 1'b1;
            len     = LEN_W'(vlen);
            bias    = exp_acc;
            tick();
            rem   = vlen;
            cnt   = 0;
            guard = 0;
            while (rem > 0 && guard < 5000) begin
                start    = ($urandom_range(0, 4) == 0);
                len      = LEN_W'($urandom_range(0, 255));
                bias     = 32'($urandom);
                in_valid = ($urandom_range(0, 3) != 0);
                in_a     = 16'($urandom);
                in_b     = 16'($urandom);
                @(negedge clk);
                n_cmp++; if (in_ready !== 1'b1 || fma_c !== exp_acc || done_cnt !== LEN_W'(cnt)) begin
                    n_err++;
                    $display("FAIL rnd_accum[v%0d c%0d]: got rdy=%0b acc=%h cnt=%0d want 1 %h %0d", v, cnt, in_ready, fma_c, done_cnt, exp_acc, cnt);
                end
                if (in_valid) begin
                    exp_acc = stub_fn(in_a, in_b, exp_acc);
                    rem--;
                    cnt++;
                end
                guard++;
                tick();
            end
            start    = 1'b0;
            in_valid = 1'b0;
            exp_q.push_back(exp_acc);
            for (int w = $urandom_range(0, 3); w > 0; w--) begin
                @(negedge clk);
                n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL rnd_wait_valid[v%0d]: got %0b want 1", v, res_valid); end
                tick();
            end
            res_ready = 1'b1;
            @(negedge clk);
            got = exp_q.pop_front();
            n_cmp++; if (res_valid !== 1'b1 || res_data !== got) begin
                n_err++;
                $display("FAIL rnd_result[v%0d]: got valid=%0b data=%h want 1 %h", v, res_valid, res_data, got);
            end
            n_cmp++; if (done_cnt !== LEN_W'(vlen)) begin n_err++; $display("FAIL rnd_done_cnt[v%0d]: got %0d want %0d", v, done_cnt, vlen); end
            tick();
            res_ready = 1'b0;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        script_mode = 1'b0;
        script_val  = '0;
        test_reset();
        test_scripted();
        test_len_zero();
        test_stall();
        test_hold_done();
        test_reset_mid();
        test_start_with_rst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter: LEN_W, default 8, width of vector-length and element-count fields.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a dot-product; sampled only in IDLE.
REQ-005 len  input  LEN_W  number of (a,b) pairs in the vector; sampled with start.
REQ-006 bias  input  32  fp32 initial accumulator value; sampled with start.
REQ-007 in_valid  input  1  operand pair present on in_a/in_b.
REQ-008 in_ready  output  1  block accepts operand pair this cycle.
REQ-009 in_a, in_b  input  16 each  16-bit float multiplicands.
REQ-010 fma_a, fma_b  output  16 each  multiplicands driven to the downstream fused multiply-add.
REQ-011 fma_c  output  32  fp32 addend driven to the fused multiply-add.
REQ-012 fma_out  input  32  fp32 result returned combinationally by the fused multiply-add.
REQ-013 res_valid  output  1  accumulated result available.
REQ-014 res_ready  input  1  consumer accepts result.
REQ-015 res_data  output  32  fp32 accumulated result.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done_cnt  output  LEN_W  pairs accepted in the current vector.

Function
REQ-018 Three states: IDLE, ACCUM, DONE; encoding is implementation choice.
REQ-019 IDLE, start=1, len!=0: acc<=bias, remaining<=len, done_cnt<=0, next state ACCUM.
REQ-020 IDLE, start=1, len=0: acc<=bias, done_cnt<=0, next state DONE (no FMA operations).
REQ-021 start outside IDLE is ignored, with no effect on any register.
REQ-022 in_ready = 1 only in ACCUM; in_ready has no combinational dependency on in_valid.
REQ-023 fma_a=in_a, fma_b=in_b, fma_c=acc, all combinational and valid in every state.
REQ-024 A beat is accepted when in_valid && in_ready; on acceptance acc<=fma_out, remaining<=remaining-1, done_cnt<=done_cnt+1.
REQ-025 ACCUM with no accepted beat: acc, remaining, and done_cnt hold.
REQ-026 Accepted beat with remaining==1: next state DONE; the final product is already in acc on DONE entry.
REQ-027 Latency: result visible one cycle after the last accepted beat; throughput is one pair per cycle.
REQ-028 DONE: res_valid=1, res_data=acc; acc is stable while res_valid=1 and res_ready=0.
REQ-029 DONE, res_ready=1: next state IDLE; a start in that same cycle is ignored.
REQ-030 res_data equals acc in all states; res_valid=0 outside DONE.
REQ-031 done_cnt saturates at 2^LEN_W-1 and does not wrap (len max = 2^LEN_W-1).
REQ-032 No arithmetic on float fields inside the block; all arithmetic is delegated to fma_*.

Reset
REQ-033 rst=1 at a rising edge: state<=IDLE, acc<=0, remaining<=0, done_cnt<=0.
REQ-034 Outputs during and after reset: in_ready=0, res_valid=0, busy=0, res_data=0.
REQ-035 Reset mid-vector (ACCUM or DONE) discards partial result with no res_valid pulse; rst takes priority over start and handshakes in the same cycle.

Verification (bench stubs fma_out as a scripted value per beat)
REQ-036 bias=0x3F800000, len=3, 3 back-to-back beats, stub returns 0x40000000/0x40400000/0x40800000 -> fma_c sequence 0x3F800000,0x40000000,0x40400000; res_valid one cycle after beat 3; res_data=0x40800000; done_cnt=3.
REQ-037 len=0, bias=0xC0A00000 -> DONE next cycle, res_data=0xC0A00000, in_ready never asserted.
REQ-038 len=4, in_valid toggled 1,0,1,0,1,1 -> exactly 4 acceptances, acc changes only on accepted cycles, done_cnt steps 1..4.
REQ-039 DONE with res_ready=0 for 5 cycles, start pulsed -> res_valid and res_data held; no restart; res_ready=1 -> IDLE next cycle.
REQ-040 rst asserted after 2 of 5 beats -> next cycle state IDLE, acc=0, done_cnt=0, busy=0, no res_valid.
REQ-041 Start in IDLE with rst=1 in the same cycle -> remains IDLE, busy=0.
